// File: rtl/ps2_key_matrix_pkg.sv
// Shared types and constants for the PS/2 to Spectrum key matrix front end.
package zx_kbd_pkg;

    // Receiver frame position
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_e;

    // Matrix coordinate of a decoded key; hit=0 means the code is not mapped
    typedef struct packed {
        logic       hit;
        logic [2:0] row;
        logic [2:0] col;
    } key_pos_t;

    // Set-2 scan codes with special meaning
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_F1     = 8'h05;
    localparam logic [7:0] SC_F11    = 8'h78;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_RALT   = 8'h11;
    localparam logic [7:0] SC_ENTER  = 8'h5A;

    // Row/column positions of the keys the decoder treats specially
    localparam int unsigned ROW_CAPS  = 0;
    localparam int unsigned COL_CAPS  = 0;
    localparam int unsigned ROW_0     = 4;
    localparam int unsigned COL_0     = 0;
    localparam int unsigned ROW_ENTER = 6;
    localparam int unsigned COL_ENTER = 0;
    localparam int unsigned ROW_SYM   = 7;
    localparam int unsigned COL_SYM   = 1;

    function automatic key_pos_t at(input int unsigned r, input int unsigned c);
        return '{hit: 1'b1, row: 3'(r), col: 3'(c)};
    endfunction

    // Translate a make/break key code into its matrix position
    function automatic key_pos_t key_map(input logic [7:0] code, input logic ext);
        key_pos_t k;
        k = '0;
        if (ext) begin
            case (code)
                SC_ENTER:         k = at(ROW_ENTER, COL_ENTER);
                SC_CTRL, SC_RALT: k = at(ROW_SYM, COL_SYM);
                default:          k = '0;
            endcase
        end else begin
            case (code)
                SC_LSHIFT, SC_RSHIFT: k = at(ROW_CAPS, COL_CAPS);
                8'h1A: k = at(0, 1);  8'h22: k = at(0, 2);  8'h21: k = at(0, 3);  8'h2A: k = at(0, 4);
                8'h1C: k = at(1, 0);  8'h1B: k = at(1, 1);  8'h23: k = at(1, 2);  8'h2B: k = at(1, 3);
                8'h34: k = at(1, 4);
                8'h15: k = at(2, 0);  8'h1D: k = at(2, 1);  8'h24: k = at(2, 2);  8'h2D: k = at(2, 3);
                8'h2C: k = at(2, 4);
                8'h16: k = at(3, 0);  8'h1E: k = at(3, 1);  8'h26: k = at(3, 2);  8'h25: k = at(3, 3);
                8'h2E: k = at(3, 4);
                8'h45: k = at(4, 0);  8'h46: k = at(4, 1);  8'h3E: k = at(4, 2);  8'h3D: k = at(4, 3);
                8'h36: k = at(4, 4);
                8'h4D: k = at(5, 0);  8'h44: k = at(5, 1);  8'h43: k = at(5, 2);  8'h3C: k = at(5, 3);
                8'h35: k = at(5, 4);
                SC_ENTER: k = at(ROW_ENTER, COL_ENTER);
                8'h4B: k = at(6, 1);  8'h42: k = at(6, 2);  8'h3B: k = at(6, 3);  8'h33: k = at(6, 4);
                8'h29: k = at(7, 0);
                SC_CTRL: k = at(ROW_SYM, COL_SYM);
                8'h3A: k = at(7, 2);  8'h31: k = at(7, 3);  8'h32: k = at(7, 4);
                default: k = '0;
            endcase
        end
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_matrix_if.sv
// ULA port #FE read bus: address from the CPU side, column data back from the keyboard.
interface ps2_key_matrix_if;
    logic [15:0] A;
    logic [4:0]  KEYB;

    modport master (output A, input  KEYB);
    modport slave  (input  A, output KEYB);
endinterface

// File: rtl/ps2_key_matrix_rx.sv
// PS/2 frame receiver: pin synchronisers, clock glitch filter, bit FSM and idle timeout.
module ps2_rx
    import zx_kbd_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 28000
) (
    input  logic       clk_sys,
    input  logic       nRESET,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       rx_valid_o,
    output logic [7:0] rx_byte_o
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_clk_q;
    logic [FW-1:0] filt_cnt_q;
    logic          filt_flip, fall_edge, dat_bit;

    rx_state_e     state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [TW-1:0] tmo_q;
    logic          rx_valid_q;
    logic [7:0]    rx_byte_q;

    // Two-flop synchronisers bring the asynchronous pins into clk_sys
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            // NOTE: non-blocking keeps each stage one cycle behind the last; blocking would collapse the chain.
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
        end
    end

    assign filt_flip = (clk_sync_q[1] != filt_clk_q) && (filt_cnt_q == FW'(FILTER - 1));
    assign fall_edge = filt_flip && filt_clk_q;
    assign dat_bit   = dat_sync_q[1];

    // Filtered clock follows the pin only after FILTER consecutive differing samples
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            filt_clk_q <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_sync_q[1] == filt_clk_q) begin
            filt_cnt_q <= '0;
        end else if (filt_flip) begin
            filt_clk_q <= ~filt_clk_q;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    // Frame FSM: one bit per filtered falling edge, aborting after TIMEOUT idle cycles mid-frame
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            if (fall_edge || state_q == IDLE) tmo_q <= '0;
            else                              tmo_q <= tmo_q + 1'b1;

            if (state_q != IDLE && !fall_edge && tmo_q == TW'(TIMEOUT - 1)) begin
                state_q <= IDLE;
            end else if (fall_edge) begin
                case (state_q)
                    IDLE: begin
                        if (!dat_bit) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {dat_bit, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= PARITY;
                    end
                    PARITY: begin
                        parity_q <= dat_bit;
                        state_q  <= STOP;
                    end
                    STOP: begin
                        if (dat_bit && (^{shift_q, parity_q})) rx_valid_q <= 1'b1;
                        rx_byte_q <= shift_q;
                        state_q   <= IDLE;
                    end
                endcase
            end
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_byte_o  = rx_byte_q;
endmodule

// File: rtl/ps2_key_matrix.sv
// PS/2 keyboard front end for the Spectrum ULA: set-2 decoder, 8x5 key matrix and port #FE column read.
module ps2_key_matrix
    import zx_kbd_pkg::*;
#(
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 28000
) (
    input  logic             clk_sys,
    input  logic             nRESET,
    input  logic             PS2_CLK,
    input  logic             PS2_DAT,
    ps2_key_matrix_if.slave  ula,
    output logic             F1,
    output logic             F11
);
    logic             rx_valid;
    logic [7:0]       rx_byte;
    key_pos_t         pos;

    logic [7:0][4:0]  pressed_q, pressed_d, eff;
    logic             bksp_q, bksp_d, f1_q, f1_d, f11_q, f11_d, ext_q, ext_d, brk_q, brk_d;
    logic [4:0]       col_any;

    ps2_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) u_rx (
        .clk_sys    (clk_sys),
        .nRESET     (nRESET),
        .ps2_clk_i  (PS2_CLK),
        .ps2_dat_i  (PS2_DAT),
        .rx_valid_o (rx_valid),
        .rx_byte_o  (rx_byte)
    );

    // Decode one received byte into prefix flags, matrix bits and function-key levels
    always_comb begin
        // NOTE: every _d starts from its _q so no branch leaves a variable unassigned (no latches).
        pressed_d = pressed_q;
        bksp_d    = bksp_q;
        f1_d      = f1_q;
        f11_d     = f11_q;
        ext_d     = ext_q;
        brk_d     = brk_q;
        pos       = key_map(rx_byte, ext_q);
        if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (pos.hit) pressed_d[pos.row][pos.col] = ~brk_q;
                if (!ext_q) begin
                    case (rx_byte)
                        SC_F1:   f1_d   = ~brk_q;
                        SC_F11:  f11_d  = ~brk_q;
                        SC_BKSP: bksp_d = ~brk_q;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Key state registers
    always_ff @(posedge clk_sys) begin
        if (!nRESET) begin
            // NOTE: the matrix is 40 ordinary flops, not a RAM, so it is cleared by reset like any state.
            pressed_q <= '0;
            bksp_q    <= 1'b0;
            f1_q      <= 1'b0;
            f11_q     <= 1'b0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            pressed_q <= pressed_d;
            bksp_q    <= bksp_d;
            f1_q      <= f1_d;
            f11_q     <= f11_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
        end
    end

    // Column read: Backspace lights CAPS and 0 without touching their physical bits
    always_comb begin
        eff                      = pressed_q;
        eff[ROW_CAPS][COL_CAPS]  = pressed_q[ROW_CAPS][COL_CAPS] | bksp_q;
        eff[ROW_0][COL_0]        = pressed_q[ROW_0][COL_0] | bksp_q;
        col_any                  = '0;
        for (int r = 0; r < 8; r++) begin
            if (!ula.A[8 + r]) col_any = col_any | eff[r];
        end
        ula.KEYB = ~col_any;
    end

    assign F1  = f1_q;
    assign F11 = f11_q;
endmodule

// File: tb/tb_ps2_key_matrix.sv
// Directed bench for ps2_key_matrix: table of scan-code frames plus corner-case sequences.
module tb_ps2_key_matrix;

    logic clk_sys = 1'b0;
    logic nRESET  = 1'b0;
    logic PS2_CLK = 1'b1;
    logic PS2_DAT = 1'b1;
    logic F1, F11;

    ps2_key_matrix_if ula ();

    ps2_key_matrix dut (
        .clk_sys (clk_sys),
        .nRESET  (nRESET),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .ula     (ula),
        .F1      (F1),
        .F11     (F11)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        send;
        logic [7:0]  code;
        logic [15:0] addr;
        logic [4:0]  keyb;
        logic        f1;
        logic        f11;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bit(input logic b);
        PS2_DAT = b;
        wait_cyc(10);
        PS2_CLK = 1'b0;
        wait_cyc(20);
        PS2_CLK = 1'b1;
        wait_cyc(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_parity);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit((~^d) ^ bad_parity);
        send_bit(1'b1);
        PS2_DAT = 1'b1;
        wait_cyc(20);
    endtask

    task automatic read_keyb(input string name, input logic [15:0] addr, input logic [4:0] exp);
        ula.A = addr;
        #1;
        check(name, {11'd0, ula.KEYB}, {11'd0, exp});
    endtask

    function automatic void add(input logic s, input logic [7:0] c, input logic [15:0] a,
                                input logic [4:0] k, input logic f1, input logic f11);
        vec_t v;
        v.send = s; v.code = c; v.addr = a; v.keyb = k; v.f1 = f1; v.f11 = f11;
        vecs.push_back(v);
    endfunction

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // send, code, address, KEYB, F1, F11
        add(1, 8'h1C, 16'hFDFE, 5'h1E, 0, 0);  // A pressed
        add(1, 8'hF0, 16'hFDFE, 5'h1E, 0, 0);  // break prefix alone changes nothing
        add(1, 8'h1C, 16'hFDFE, 5'h1F, 0, 0);  // A released
        add(1, 8'h1C, 16'hFDFE, 5'h1E, 0, 0);  // typematic repeats
        add(1, 8'h1C, 16'hFDFE, 5'h1E, 0, 0);
        add(0, 8'h00, 16'hFFFF, 5'h1F, 0, 0);  // no row selected
        add(1, 8'hF0, 16'hFDFE, 5'h1E, 0, 0);
        add(1, 8'h1C, 16'hFDFE, 5'h1F, 0, 0);  // single break releases after repeats
        add(1, 8'hF0, 16'hFEFE, 5'h1F, 0, 0);
        add(1, 8'h2A, 16'hFEFE, 5'h1F, 0, 0);  // break of unpressed V is a no-op
        add(1, 8'h12, 16'hFEFE, 5'h1E, 0, 0);  // LShift -> CAPS
        add(0, 8'h00, 16'hEFFE, 5'h1F, 0, 0);
        add(1, 8'h66, 16'hFEFE, 5'h1E, 0, 0);  // Backspace with CAPS held
        add(0, 8'h00, 16'hEFFE, 5'h1E, 0, 0);  // ... and lights 0
        add(1, 8'hF0, 16'hEFFE, 5'h1E, 0, 0);
        add(1, 8'h66, 16'hFEFE, 5'h1E, 0, 0);  // CAPS still physically held
        add(0, 8'h00, 16'hEFFE, 5'h1F, 0, 0);
        add(1, 8'hF0, 16'hFEFE, 5'h1E, 0, 0);
        add(1, 8'h12, 16'hFEFE, 5'h1F, 0, 0);
        add(1, 8'h1A, 16'hFAFE, 5'h1D, 0, 0);  // Z in row 0
        add(1, 8'h2C, 16'hFAFE, 5'h0D, 0, 0);  // T in row 2, rows combine
        add(0, 8'h00, 16'hFBFF, 5'h0F, 0, 0);  // row 2 alone
        add(1, 8'hF0, 16'hFAFE, 5'h0D, 0, 0);
        add(1, 8'h1A, 16'hFAFE, 5'h0F, 0, 0);
        add(1, 8'hF0, 16'hFAFE, 5'h0F, 0, 0);
        add(1, 8'h2C, 16'hFAFE, 5'h1F, 0, 0);
        add(1, 8'hE0, 16'h7FFE, 5'h1F, 0, 0);
        add(1, 8'h14, 16'h7FFE, 5'h1D, 0, 0);  // RCtrl -> SYM
        add(1, 8'hE0, 16'h7FFE, 5'h1D, 0, 0);
        add(1, 8'h75, 16'h7FFE, 5'h1D, 0, 0);  // unmapped extended code
        add(1, 8'hE0, 16'hFDFE, 5'h1F, 0, 0);
        add(1, 8'h1C, 16'hFDFE, 5'h1F, 0, 0);  // A with E0 prefix is ignored
        add(1, 8'hE0, 16'h7FFE, 5'h1D, 0, 0);
        add(1, 8'hF0, 16'h7FFE, 5'h1D, 0, 0);
        add(1, 8'h14, 16'h7FFE, 5'h1F, 0, 0);  // RCtrl released
        add(1, 8'h11, 16'h7FFE, 5'h1F, 0, 0);  // LAlt unmapped
        add(1, 8'h14, 16'h7FFE, 5'h1D, 0, 0);  // LCtrl -> SYM
        add(1, 8'hF0, 16'h7FFE, 5'h1D, 0, 0);
        add(1, 8'h14, 16'h7FFE, 5'h1F, 0, 0);
        add(1, 8'hE0, 16'hBFFE, 5'h1F, 0, 0);
        add(1, 8'h5A, 16'hBFFE, 5'h1E, 0, 0);  // keypad Enter -> ENTER
        add(1, 8'hE0, 16'hBFFE, 5'h1E, 0, 0);
        add(1, 8'hF0, 16'hBFFE, 5'h1E, 0, 0);
        add(1, 8'h5A, 16'hBFFE, 5'h1F, 0, 0);
        add(1, 8'h05, 16'h00FE, 5'h1F, 1, 0);  // F1 level
        add(1, 8'hF0, 16'h00FE, 5'h1F, 1, 0);
        add(1, 8'h05, 16'h00FE, 5'h1F, 0, 0);
        add(1, 8'h78, 16'h00FE, 5'h1F, 0, 1);  // F11 level
        add(1, 8'hF0, 16'h00FE, 5'h1F, 0, 1);
        add(1, 8'h78, 16'h00FE, 5'h1F, 0, 0);

        // Reset state
        ula.A = 16'h00FE;
        wait_cyc(5);
        read_keyb("reset_keyb", 16'h00FE, 5'h1F);
        check("reset_f1", {15'd0, F1}, 16'd0);
        check("reset_f11", {15'd0, F11}, 16'd0);
        nRESET = 1'b1;
        wait_cyc(20);

        // Table of single-frame vectors
        foreach (vecs[i]) begin
            if (vecs[i].send) send_frame(vecs[i].code, 1'b0);
            read_keyb($sformatf("vec%0d_keyb", i), vecs[i].addr, vecs[i].keyb);
            check($sformatf("vec%0d_f1", i), {15'd0, F1}, {15'd0, vecs[i].f1});
            check($sformatf("vec%0d_f11", i), {15'd0, F11}, {15'd0, vecs[i].f11});
        end

        // Bad parity frame is dropped; the following good frame is taken
        send_frame(8'h1C, 1'b1);
        read_keyb("badpar_dropped", 16'hFDFE, 5'h1F);
        send_frame(8'h1C, 1'b0);
        read_keyb("badpar_next_ok", 16'hFDFE, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        read_keyb("badpar_release", 16'hFDFE, 5'h1F);

        // Partial frame abandoned for longer than the timeout
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        PS2_DAT = 1'b1;
        wait_cyc(28100);
        send_frame(8'h29, 1'b0);
        read_keyb("timeout_space", 16'h7FFE, 5'h1E);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        read_keyb("timeout_release", 16'h7FFE, 5'h1F);

        // Reset in the middle of a frame with keys held
        send_frame(8'h1C, 1'b0);
        send_frame(8'h78, 1'b0);
        read_keyb("prereset_keyb", 16'hFDFE, 5'h1E);
        check("prereset_f11", {15'd0, F11}, 16'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        nRESET = 1'b0;
        wait_cyc(2);
        read_keyb("midreset_keyb", 16'hFDFE, 5'h1F);
        check("midreset_f11", {15'd0, F11}, 16'd0);
        check("midreset_f1", {15'd0, F1}, 16'd0);
        nRESET = 1'b1;
        PS2_DAT = 1'b1;
        wait_cyc(30);
        send_frame(8'h1C, 1'b0);
        read_keyb("postreset_frame", 16'hFDFE, 5'h1E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
